// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM-to-UART dump path.
package vram_pkg;

  localparam int VRAM_DEPTH = 751;
  localparam int VRAM_COLS  = 50;
  localparam int VRAM_AW    = 12;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_READ   = 4'd1,
    S_LATCH  = 4'd2,
    S_SEND   = 4'd3,
    S_SETTLE = 4'd4,
    S_WAIT   = 4'd5,
    S_NEXT   = 4'd6,
    S_CR     = 4'd7,
    S_LF     = 4'd8,
    S_FIN    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    PH_DATA = 2'd0,
    PH_CR   = 2'd1,
    PH_LF   = 2'd2
  } phase_t;

endpackage

// File: rtl/vram_uart_dump.sv
// Streams VRAM cells 0..DEPTH-1 to uart_tx, one byte per cell.
// Optional CR/LF after every COLS bytes and after the last byte: VRAM_DUMP_CRLF_EN.
module vram_uart_dump
  import vram_pkg::*;
#(
  parameter int DEPTH = VRAM_DEPTH,
  parameter int COLS  = VRAM_COLS,
  parameter int AW    = VRAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ram_ce,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_data,
  output logic [7:0]    tx_data,
  output logic          tx_ready,
  input  logic          tx_busy,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if (DEPTH < 1 || COLS < 1) begin : g_bad_cfg
    $error("vram_uart_dump: DEPTH and COLS must both be at least 1");
  end

  state_t state, state_nx;
  state_t wait_exit, next_exit;
  logic   settle;
  logic   at_last;

  assign at_last = (ram_addr == LAST_ADDR);

`ifdef VRAM_DUMP_CRLF_EN
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [CW-1:0] col;
  phase_t        phase;
  logic          fin_pend;

  // Route WAIT/NEXT exits through the CR/LF pair at row ends and after the last byte
  always_comb begin
    wait_exit = S_NEXT;
    case (phase)
      PH_CR:   wait_exit = S_LF;
      PH_LF:   wait_exit = fin_pend ? S_FIN : S_READ;
      default: wait_exit = S_NEXT;
    endcase
    next_exit = (at_last || col == COL_LAST) ? S_CR : S_READ;
  end

  // Column counter, byte-kind tracking and end-of-dump flag for the line-break path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      phase    <= PH_DATA;
      fin_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          col      <= '0;
          phase    <= PH_DATA;
          fin_pend <= 1'b0;
        end
        S_NEXT: begin
          col      <= (col == COL_LAST) ? '0 : col + CW'(1);
          fin_pend <= at_last;
        end
        S_READ:  phase <= PH_DATA;
        S_CR:    phase <= PH_CR;
        S_LF:    phase <= PH_LF;
        default: ;
      endcase
    end
  end
`else
  assign wait_exit = S_NEXT;
  assign next_exit = at_last ? S_FIN : S_READ;
`endif

  // Next-state logic; tx_busy is only looked at in WAIT
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = start ? S_READ : S_IDLE;
      S_READ:   state_nx = S_LATCH;
      S_LATCH:  state_nx = S_SEND;
      S_SEND:   state_nx = S_SETTLE;
      S_SETTLE: state_nx = settle ? S_WAIT : S_SETTLE;
      S_WAIT:   state_nx = tx_busy ? S_WAIT : wait_exit;
      S_NEXT:   state_nx = next_exit;
      S_CR:     state_nx = S_SEND;
      S_LF:     state_nx = S_SEND;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register, registered strobes and the address/data datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ram_ce   <= 1'b0;
      ram_addr <= '0;
      tx_data  <= 8'h00;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      settle   <= 1'b0;
    end else begin
      state    <= state_nx;
      ram_ce   <= (state_nx == S_READ);
      tx_ready <= (state_nx == S_SEND);
      busy     <= (state_nx != S_IDLE);
      done     <= (state_nx == S_FIN);
      settle   <= (state == S_SETTLE) ? ~settle : 1'b0;
      case (state)
        S_IDLE:  if (start) ram_addr <= '0;
        S_LATCH: tx_data <= ram_data;
        S_NEXT:  if (!at_last) ram_addr <= ram_addr + AW'(1);
        S_CR:    tx_data <= CH_CR;
        S_LF:    tx_data <= CH_LF;
        default: ;
      endcase
    end
  end

endmodule
